// File: rtl/mdu_controller.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiply and restoring
// divide on a shared 2*WIDTH accumulator, with a pipeline stall request.
module mdu_controller #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [RADDR-1:0] rd_e,
  input  logic             kill,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [RADDR-1:0] rd_out
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q;
  logic [2:0]         f3_q;
  logic [RADDR-1:0]   rd_q, rd_out_q;
  logic [WIDTH-1:0]   opb_q, result_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_q, neg_r_q, done_q;
  logic [5:0]         cnt_q;

  logic               a_signed, b_signed, div_zero, div_ovf;
  logic [WIDTH-1:0]   a_mag, b_mag, spec_res;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, acc_nxt, prod;
  logic [WIDTH-1:0]   quo_s, rem_s, fin_res;
  logic               last;

  always_comb begin
    a_signed = funct3[2] ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
    b_signed = funct3[2] ? ~funct3[0] : (funct3 == 3'b001);
  end

  assign a_mag    = (a_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign b_mag    = (b_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  assign div_zero = (op_b == '0);
  assign div_ovf  = ~funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
  // Divide-by-zero wins over overflow; both skip the iteration entirely.
  assign spec_res = div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : MIN_NEG);

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, quotient}.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_nxt  = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_sh - {1'b0, opb_q};
  assign div_nxt  = {div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0],
                     acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
  assign acc_nxt  = (state_q == S_MUL) ? mul_nxt : div_nxt;
  assign last     = (cnt_q == 6'(WIDTH-1));

  assign prod    = neg_q ? -mul_nxt : mul_nxt;
  assign quo_s   = neg_q ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
  assign rem_s   = neg_r_q ? -div_nxt[2*WIDTH-1:WIDTH] : div_nxt[2*WIDTH-1:WIDTH];
  assign fin_res = (state_q == S_MUL) ?
                   ((f3_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]) :
                   (f3_q[1] ? rem_s : quo_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      f3_q     <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      opb_q    <= '0;
      result_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (kill) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            f3_q    <= funct3;
            rd_q    <= rd_e;
            cnt_q   <= '0;
            neg_q   <= (a_signed & op_a[WIDTH-1]) ^ (b_signed & op_b[WIDTH-1]);
            neg_r_q <= a_signed & op_a[WIDTH-1];
            if (funct3[2]) begin
              acc_q <= {{WIDTH{1'b0}}, a_mag};
              opb_q <= b_mag;
            end else begin
              acc_q <= {{WIDTH{1'b0}}, b_mag};
              opb_q <= a_mag;
            end
            if (funct3[2] && (div_zero || div_ovf)) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= spec_res;
              rd_out_q <= rd_e;
            end else begin
              state_q <= funct3[2] ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL, S_DIV: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + 6'd1;
          if (last) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= fin_res;
            rd_out_q <= rd_q;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_req = ~kill & (((state_q == S_IDLE) & start) | (state_q == S_MUL) |
                              (state_q == S_DIV));
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign rd_out    = rd_out_q;

endmodule

// File: tb/tb_mdu_controller.sv
// Directed bench for mdu_controller: latency, stall window, results, kill and async reset.
module tb_mdu_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [4:0]  rd_e = '0;
  logic        kill = 1'b0;
  logic        stall_req, busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_vec = 0;
  int n_err = 0;

  mdu_controller #(.WIDTH(32), .RADDR(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op_a(op_a),
    .op_b(op_b), .rd_e(rd_e), .kill(kill), .stall_req(stall_req), .busy(busy),
    .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Issue one op at a negedge (T0) and follow it until done or a cycle budget.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat = 0;
    int stall_cyc = 0;
    bit seen = 0;
    @(negedge clk);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_e = rd;
    #1;
    if (stall_req) stall_cyc++;
    while (!seen && lat < 60) begin
      @(negedge clk);
      start = 1'b0; op_a = 32'h0; op_b = 32'h0; rd_e = 5'd0;
      #1;
      lat++;
      if (stall_req) stall_cyc++;
      if (done) seen = 1;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " stall_cycles"}, 32'(stall_cyc), 32'(exp_lat));
    chk({tag, " result"}, result, exp_res);
    chk({tag, " rd_out"}, 32'(rd_out), 32'(rd));
    @(negedge clk); #1;
    chk({tag, " done_pulse_width"}, 32'(done), 32'd0);
    chk({tag, " idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int seen_done;
    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rd_out", 32'(rd_out), 32'd0);
    chk("reset stall", 32'(stall_req), 32'd0);
    rst_n = 1'b1;

    run_op("MUL",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 33);
    run_op("MULH",   3'b001, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 33);
    run_op("MULHU",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 33);
    run_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'd2,        5'd6,  32'hFFFFFFFF, 33);
    run_op("DIV",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 33);
    run_op("REM",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 33);
    run_op("REMU",   3'b111, 32'd100,      32'd7,        5'd9,  32'd2,        33);
    run_op("DIVU0",  3'b101, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1);
    run_op("REM0",   3'b110, 32'd5,        32'd0,        5'd11, 32'd5,        1);
    run_op("DIVOVF", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1);
    run_op("REMOVF", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        1);

    // kill beats start in IDLE
    @(negedge clk);
    start = 1'b1; kill = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3;
    #1 chk("kill_prio stall", 32'(stall_req), 32'd0);
    @(negedge clk); start = 1'b0; kill = 1'b0;
    #1 chk("kill_prio busy", 32'(busy), 32'd0);

    // kill at T10 of a MUL
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; rd_e = 5'd20;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); start = 1'b0;
    end
    kill = 1'b1;
    #1 chk("kill T10 stall", 32'(stall_req), 32'd0);
    @(negedge clk); kill = 1'b0;
    #1;
    chk("kill T11 busy", 32'(busy), 32'd0);
    chk("kill T11 stall", 32'(stall_req), 32'd0);
    chk("kill result kept", result, 32'd0);
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (done) seen_done++;
    end
    chk("kill no done", 32'(seen_done), 32'd0);
    run_op("MUL after kill", 3'b000, 32'd12345, 32'd1000, 5'd21, 32'd12345000, 33);

    // async reset at T15 of a DIV
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3; rd_e = 5'd22;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk); start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst rd_out", 32'(rd_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done) seen_done++;
    end
    chk("rst no done", 32'(seen_done), 32'd0);
    run_op("DIVU after rst", 3'b101, 32'd1000, 32'd3, 5'd23, 32'd333, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_controller.md
# mdu_controller

Multi-cycle sequencer for the RV32M multiply/divide operations of the 5-stage pipeline. It sits beside the execute-stage ALU, accepts one M-extension instruction at a time, and iterates a shared shift-add/restoring-divide datapath. It raises a stall request that the pipeline control ORs with the load-use stall, so fetch, decode and execute hold until the result is ready.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- RADDR, 5, register-address width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  execute-stage instruction is valid M-ext (opcode 0110011, funct7 0000001)
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  WIDTH  rs1 value (post-forwarding)
- op_b  in  WIDTH  rs2 value (post-forwarding)
- rd_e  in  RADDR  destination register of the execute-stage instruction
- kill  in  1  abandon the current operation (trap/redirect)
- stall_req  out  1  hold F/D/E; combinational
- busy  out  1  state is not IDLE
- done  out  1  result valid this cycle, single-cycle pulse
- result  out  WIDTH  selected result
- rd_out  out  RADDR  destination of the completed operation

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE with start=1 and kill=0:
  - Latch funct3, rd_e, operand magnitudes and result-sign flags.
  - Clear the 6-bit iteration counter.
  - Go to MUL for funct3[2]=0, otherwise DIV.
- Divide special cases go straight from IDLE to DONE:
  - op_b=0: quotient=all ones, remainder=op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
- MUL: one shift-add step per cycle on a 2*WIDTH accumulator, 32 iterations, then DONE.
  - Sign handling: MULH negates both signed operands, MULHSU negates only op_a, MULHU and MUL use the raw values.
  - The final product is negated if the sign flag is set.
  - MUL returns the low word; MULH/MULHSU/MULHU return the high word.
- DIV: one restoring step per cycle, 32 iterations, then DONE.
  - Quotient is negated when the signs differ (DIV only).
  - Remainder takes the dividend's sign (REM only).
  - Unsigned variants use the raw values.
- DONE: done=1, result and rd_out valid. Next state is IDLE unconditionally, and start is ignored in DONE.
- stall_req = ~kill & ((IDLE & start) | MUL | DIV).
- kill in any state: next state IDLE, no done pulse, result keeps its previous value. kill has priority over start.
- Reset values: state IDLE; counter 0; stall_req 0 (since start is 0 or kill is 1); busy 0; done 0; result 0; rd_out 0.

## Timing
- T0: start seen in IDLE; stall_req=1 combinationally; operands captured at the T0 edge.
- MUL/DIV: states occupy T1..T32 (stall_req=1). T33 is DONE (stall_req=0, done=1). The pipeline advances at the T33 edge, and EX/MEM captures result.
- Special-case divide: stall only in T0, DONE at T1.
- A new start is accepted no earlier than the cycle after DONE (one IDLE cycle).
- rst_n low at any point: all state clears immediately; no done follows the release.

## Test plan
- MUL 7 × 0xFFFFFFFD: stall_req high T0..T32, done at T33 with result=0xFFFFFFEB, rd_out=rd_e.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; REMU 100 % 7 → 2; each done at T33.
- DIVU 5 / 0 → 0xFFFFFFFF with done at T1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, each with done at T1.
- kill asserted at T10 of a MUL: IDLE at T11, no done pulse, stall_req=0. A following start completes correctly at 33 cycles.
- rst_n pulsed low at T15 of a DIV: busy, done and result go to 0 asynchronously; no done after release.
